// File: rtl/sd2_decim.sv
// Sinc3 CIC decimator for the second-order sigma-delta bitstream.
// Wrapping integrators, one comb pass per frame, saturated OW-bit output.
module sd2_decim #(
  parameter int LOGR = 6,
  parameter int OW   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bs_in,
  input  logic                 bs_valid,
  output logic signed [OW-1:0] dout,
  output logic                 dout_valid
);

  localparam int W  = 3*LOGR + 2;
  localparam int SH = 3*LOGR - OW + 1;

  localparam logic signed [W-1:0] PMAX =
    W'((64'sd1 <<< (OW-1)) - 64'sd1);
  localparam logic signed [W-1:0] NMIN =
    -PMAX - W'(1);

  logic signed [W-1:0] r_i1, r_i2, r_i3;
  logic signed [W-1:0] r_d1, r_d2, r_d3;
  logic signed [W-1:0] r_y;
  logic [LOGR-1:0]     r_cnt;
  logic                r_tick;
  logic                r_yv;

  logic signed [W-1:0]  w_x;
  logic signed [W-1:0]  w_c1, w_c2, w_c3;
  logic signed [W-1:0]  w_sh;
  logic signed [OW-1:0] w_sat;

  assign w_x = bs_in ? W'(1) : {W{1'b1}};

  assign w_c1 = r_i3 - r_d1;
  assign w_c2 = w_c1 - r_d2;
  assign w_c3 = w_c2 - r_d3;

  assign w_sh = r_y >>> SH;

  // Only +full scale can exceed the range; both ends kept for safety.
  always_comb begin
    w_sat = w_sh[OW-1:0];
    if (w_sh > PMAX)
      w_sat = PMAX[OW-1:0];
    else if (w_sh < NMIN)
      w_sat = NMIN[OW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i1       <= '0;
      r_i2       <= '0;
      r_i3       <= '0;
      r_cnt      <= '0;
      r_tick     <= 1'b0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_d3       <= '0;
      r_y        <= '0;
      r_yv       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (bs_valid) begin
        r_i1  <= r_i1 + w_x;
        r_i2  <= r_i2 + r_i1;
        r_i3  <= r_i3 + r_i2;
        r_cnt <= r_cnt + LOGR'(1);
      end
      r_tick <= bs_valid && (r_cnt == '1);
      r_yv   <= r_tick;
      if (r_tick) begin
        r_d1 <= r_i3;
        r_d2 <= w_c1;
        r_d3 <= w_c2;
        r_y  <= w_c3;
      end
      dout_valid <= r_yv;
      if (r_yv)
        dout <= w_sat;
    end
  end

endmodule

// File: tb/tb_sd2_decim.sv
// Scoreboard bench for sd2_decim: directed bitstreams, gaps, async reset.
// Second instance at LOGR=2 checks the 4-cycle strobe cadence.
module tb_sd2_decim;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic bs_in = 1'b0;
  logic bs_valid = 1'b0;
  logic signed [15:0] dout;
  logic dout_valid;
  logic signed [6:0] dout2;
  logic dout2_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int v;
    int c;
  } exp_t;

  exp_t q[$];
  exp_t me;

  int tab [3][3] = '{
    '{5208, 27048, 32767},
    '{-5208, -27048, -32768},
    '{124, 132, 0}
  };

  int acc = 0;
  int frm = 0;
  int pat = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sd2_decim #(.LOGR(6), .OW(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bs_in(bs_in),
    .bs_valid(bs_valid),
    .dout(dout),
    .dout_valid(dout_valid)
  );

  sd2_decim #(.LOGR(2), .OW(7)) dut2 (
    .clk(clk),
    .reset_n(reset_n),
    .bs_in(1'b1),
    .bs_valid(1'b1),
    .dout(dout2),
    .dout_valid(dout2_valid)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && dout_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        me = q.pop_front();
        chk("dout", int'(dout), me.v);
        chk("strobe_cycle", cyc, me.c);
      end
    end
  end

  int n2 = 0;
  int last2 = 0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n2 = 0;
    end else if (dout2_valid) begin
      n2++;
      if (n2 > 1)
        chk("r4_spacing", cyc - last2, 4);
      chk("r4_dout", int'(dout2),
          (n2 == 1) ? 4 : (n2 == 2) ? 44 : 63);
      last2 = cyc;
    end
  end

  task automatic drive(input logic b, input logic v);
    exp_t e;
    @(posedge clk);
    #1;
    bs_in = b;
    bs_valid = v;
    if (v) begin
      acc++;
      if (acc % 64 == 0) begin
        frm++;
        e.v = tab[pat][(frm >= 3) ? 2 : frm - 1];
        e.c = cyc + 3;
        q.push_back(e);
      end
    end
  endtask

  task automatic feed(input int target, input bit gapped);
    logic b;
    logic v;
    while (acc < target) begin
      v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      case (pat)
        0: b = 1'b1;
        1: b = 1'b0;
        default: b = (acc % 2 == 0);
      endcase
      drive(b, v);
    end
  endtask

  task automatic drain();
    repeat (4) drive(1'b0, 1'b0);
    chk("sb_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bs_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    acc = 0;
    frm = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    #10;
    chk("init_dout", int'(dout), 0);
    chk("init_valid", int'(dout_valid), 0);

    for (int p = 0; p < 3; p++) begin
      pat = p;
      do_reset();
      feed(5 * 64, 1'b0);
      drain();
    end

    pat = 0;
    do_reset();
    feed(5 * 64, 1'b1);
    drain();

    pat = 0;
    do_reset();
    feed(4 * 64 + 30, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    chk("pre_rst_dout", int'(dout), 32767);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_dout", int'(dout), 0);
    chk("async_valid", int'(dout_valid), 0);
    #1 reset_n = 1'b1;
    acc = 0;
    frm = 0;
    chk("sb_after_rst", q.size(), 0);
    feed(3 * 64, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
